// File: rtl/mem_arb_pkg.sv
// Shared definitions for the multi-channel byte-serial memory arbiter.
//   state_t    : arbiter FSM encoding (IDLE / RD / WR / DONE)
//   LEN_*      : request length codes carried on ch_len
//   IO_BASE    : start of the memory-mapped IO window
//   len_bytes(): length code -> byte count (the illegal code 2'b10 counts as 4 bytes)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  LEN_1B  = 2'b00;
  localparam logic [1:0]  LEN_2B  = 2'b01;
  localparam logic [1:0]  LEN_4B  = 2'b11;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_1B:  return 3'd1;
      LEN_2B:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request channels plus the byte-serial RAM/IO bus, bundled into one interface.
//   ch_req/ch_we/ch_len/ch_addr/ch_wdata/ch_abort : per-channel request side (packed, channel-major)
//   ch_done/ch_rdata                              : completion pulse and read data
//   mem_din/mem_dout/mem_a/mem_wr                 : memory pins
// slave  : the arbiter's view.
// master : the requester/memory-system view.
interface mem_arbiter_if #(parameter int NUM_CH = 2);

  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_we;
  logic [2*NUM_CH-1:0]  ch_len;
  logic [32*NUM_CH-1:0] ch_addr;
  logic [32*NUM_CH-1:0] ch_wdata;
  logic [NUM_CH-1:0]    ch_abort;
  logic [NUM_CH-1:0]    ch_done;
  logic [31:0]          ch_rdata;
  logic [7:0]           mem_din;
  logic [7:0]           mem_dout;
  logic [31:0]          mem_a;
  logic                 mem_wr;

  modport slave (
    input  ch_req, ch_we, ch_len, ch_addr, ch_wdata, ch_abort, mem_din,
    output ch_done, ch_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ch_req, ch_we, ch_len, ch_addr, ch_wdata, ch_abort, mem_din,
    input  ch_done, ch_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational channel picker.
//   i_req : candidate requests (already masked by abort)
//   i_ptr : round-robin pointer (last winner); ignored in fixed mode
//   o_gnt : one-hot grant (all zero when nothing requests)
//   o_idx : index of the granted channel (0 when nothing requests)
// ARB_MODE 0 picks the lowest set index. ARB_MODE 1 scans from i_ptr+1 with wrap.
module mem_arb_pick #(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = 0,
  parameter int IDX_W    = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Both scans walk from lowest to highest priority, so the last hit is the winner.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_cand = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        w_cand = IDX_W'(i);
        if (i_req[w_cand]) o_idx = w_cand;
      end
    end else begin
      for (int off = NUM_CH; off >= 1; off--) begin
        w_cand = IDX_W'((int'(i_ptr) + off) % NUM_CH);
        if (i_req[w_cand]) o_idx = w_cand;
      end
    end
    if (|i_req) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// NUM_CH-channel arbiter onto a single byte-serial RAM/IO bus.
//   clk, rst : clock and synchronous active-high reset
//   rdy_in   : global ready; while low, all state holds and mem_wr is forced to 0
//   bus      : channel requests/completions and memory pins (mem_arbiter_if.slave)
// Transactions are 1/2/4 bytes long. Each cycle issues one byte address.
// Read bytes come back one cycle after their address.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 18,
  parameter int ARB_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy_in,
  mem_arbiter_if.slave   bus
);

  localparam int          IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << ADDR_W) - 32'd1);

  state_t            r_state,    w_state_next;
  logic [IDX_W-1:0]  r_ptr,      w_ptr_next;
  logic [IDX_W-1:0]  r_owner,    w_owner_next;
  logic [2:0]        r_nbytes,   w_nbytes_next;
  logic [2:0]        r_cnt,      w_cnt_next;
  logic [31:0]       r_addr,     w_addr_next;
  logic [31:0]       r_wdata,    w_wdata_next;
  logic [31:0]       r_buf,      w_buf_next;
  logic [31:0]       r_rdata,    w_rdata_next;
  logic [31:0]       r_mem_a,    w_mem_a_next;
  logic [7:0]        r_mem_dout, w_mem_dout_next;
  logic              r_mem_wr,   w_mem_wr_next;
  logic [NUM_CH-1:0] r_done,     w_done_next;

  logic [NUM_CH-1:0] w_gnt;
  logic [IDX_W-1:0]  w_win;
  logic [31:0]       w_byte_ins;
  logic [1:0]        w_ch_len   [NUM_CH];
  logic [31:0]       w_ch_addr  [NUM_CH];
  logic [31:0]       w_ch_wdata [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_ch_len[gi]   = bus.ch_len[2*gi +: 2];
    assign w_ch_addr[gi]  = bus.ch_addr[32*gi +: 32];
    assign w_ch_wdata[gi] = bus.ch_wdata[32*gi +: 32];
  end

  // An aborting channel never wins a grant.
  mem_arb_pick #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE), .IDX_W(IDX_W)) u_pick (
    .i_req (bus.ch_req & ~bus.ch_abort),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win)
  );

  // Read capture: in RD count r_cnt = k (k >= 1), mem_din carries byte k-1.
  always_comb begin
    w_byte_ins = r_buf;
    for (int b = 0; b < 4; b++) begin
      if (b + 1 == int'(r_cnt)) w_byte_ins[8*b +: 8] = bus.mem_din;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_owner_next    = r_owner;
    w_nbytes_next   = r_nbytes;
    w_cnt_next      = r_cnt;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
    w_buf_next      = r_buf;
    w_rdata_next    = r_rdata;
    w_mem_a_next    = r_mem_a;
    w_mem_dout_next = r_mem_dout;
    w_mem_wr_next   = r_mem_wr;
    w_done_next     = r_done;

    case (r_state)
      ST_IDLE: begin
        if (|w_gnt) begin
          w_owner_next  = w_win;
          w_nbytes_next = len_bytes(w_ch_len[w_win]);
          w_addr_next   = w_ch_addr[w_win];
          w_wdata_next  = w_ch_wdata[w_win];
          w_cnt_next    = 3'd0;
          w_buf_next    = '0;
          w_mem_a_next  = w_ch_addr[w_win];
          if (ARB_MODE != 0) w_ptr_next = w_win;
          if (bus.ch_we[w_win]) begin
            w_state_next    = ST_WR;
            w_mem_wr_next   = 1'b1;
            w_mem_dout_next = w_ch_wdata[w_win][7:0];
          end else begin
            w_state_next  = ST_RD;
            w_mem_wr_next = 1'b0;
          end
        end
      end

      // r_wdata shifts right so its low byte is always the byte on mem_dout.
      ST_WR: begin
        if (r_cnt + 3'd1 == r_nbytes) begin
          w_state_next         = ST_DONE;
          w_mem_wr_next        = 1'b0;
          w_rdata_next         = '0;
          w_done_next          = '0;
          w_done_next[r_owner] = 1'b1;
        end else begin
          w_cnt_next      = r_cnt + 3'd1;
          w_mem_a_next    = r_addr + {29'd0, r_cnt} + 32'd1;
          w_wdata_next    = r_wdata >> 8;
          w_mem_dout_next = r_wdata[15:8];
        end
      end

      // Addresses go out for counts 0..L-1 and bytes land for counts 1..L.
      // Abort leaves mem_a parked on the last issued address.
      ST_RD: begin
        if (bus.ch_abort[r_owner]) begin
          w_state_next = ST_IDLE;
        end else begin
          if (r_cnt != 3'd0) w_buf_next = w_byte_ins;
          if (r_cnt == r_nbytes) begin
            w_state_next         = ST_DONE;
            w_rdata_next         = w_byte_ins;
            w_done_next          = '0;
            w_done_next[r_owner] = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
            if (r_cnt + 3'd1 < r_nbytes) w_mem_a_next = r_addr + {29'd0, r_cnt} + 32'd1;
          end
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_done_next  = '0;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= IDX_W'(NUM_CH - 1);
      r_owner    <= '0;
      r_nbytes   <= 3'd0;
      r_cnt      <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_rdata    <= '0;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
      r_mem_wr   <= 1'b0;
      r_done     <= '0;
    end else if (rdy_in) begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_owner    <= w_owner_next;
      r_nbytes   <= w_nbytes_next;
      r_cnt      <= w_cnt_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
      r_buf      <= w_buf_next;
      r_rdata    <= w_rdata_next;
      r_mem_a    <= w_mem_a_next;
      r_mem_dout <= w_mem_dout_next;
      r_mem_wr   <= w_mem_wr_next;
      r_done     <= w_done_next;
    end
  end

  assign bus.mem_a    = r_mem_a & ADDR_MASK;
  assign bus.mem_dout = r_mem_dout;
  assign bus.mem_wr   = r_mem_wr & rdy_in;
  assign bus.ch_done  = r_done;
  assign bus.ch_rdata = r_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised successor to the two-client memory controller. Arbitrates NUM_CH request channels onto the single byte-serial RAM/IO bus. Supports 1/2/4-byte reads and writes, fixed-priority or round-robin arbitration, and per-channel read abort (fetch flush on branch). Sits between the IF/MEM stages and the cpu memory pins (mem_a/mem_dout/mem_din/mem_wr).

Parameters:
NUM_CH, 2, number of request channels; channel 0 is highest priority in fixed mode (0=data, 1=ifetch by convention).
ADDR_W, 18, significant address bits; mem_a[31:ADDR_W] driven 0.
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes block
ch_req  in  NUM_CH  request per channel, held until ch_done
ch_we  in  NUM_CH  1 = write
ch_len  in  2*NUM_CH  byte count: 00=1B, 01=2B, 11=4B (10 illegal, treated as 4B)
ch_addr  in  32*NUM_CH  start byte address
ch_wdata  in  32*NUM_CH  write data, little-endian
ch_abort  in  NUM_CH  cancel an in-progress read
ch_done  out  NUM_CH  one-cycle completion pulse
ch_rdata  out  32  read data, valid while any ch_done bit is high
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, ch_done=0, ch_rdata=0, round-robin pointer=NUM_CH-1 (so channel 0 wins first).
- States: IDLE, RD, WR, DONE.
- IDLE: at a clock edge with any unmasked ch_req, latch the winner's we/len/addr/wdata and go to RD or WR. Call that edge T. A channel with ch_abort high is masked.
- Arbitration: fixed mode selects the lowest set index. Round-robin mode scans from pointer+1 with wrap; the pointer updates to the winner at grant.
- WR: mem_wr=1, mem_a=addr+i, mem_dout=wdata[8i+7:8i] in cycles T+1..T+L, where L = number of bytes. DONE in cycle T+L+1.
- RD: mem_a=addr+i in cycles T+1..T+L with mem_wr=0. The byte for address i appears on mem_din in cycle T+2+i and is captured into rdata[8i+7:8i]. DONE in cycle T+L+2.
- Unused upper rdata bytes are 0. Sign extension is the requester's job.
- DONE: ch_done[owner]=1 for one cycle with ch_rdata valid, then IDLE. IDLE may grant at the edge ending the DONE cycle's successor cycle. A re-asserted req is not re-granted until IDLE.
- Address increment is 32-bit and wraps at 2^32. Only the low ADDR_W bits appear on mem_a.
- Abort: ch_abort[owner] sampled high during RD sends the block to IDLE at the next edge.
  - No ch_done is issued.
  - mem_a issue stops and late mem_din bytes are ignored.
  - Abort during WR or DONE, or on a non-owner channel, has no effect.
- ch_req deasserted mid-transaction: ignored; the transaction completes.
- rdy_in low: every register holds (state, counters, pointer, outputs) and mem_wr is gated to 0. The memory system pauses in lockstep. Operation resumes exactly where it stopped.
- Reset mid-transaction: immediate return to reset values. No done is issued.
- Zero-wait: an address pipelines one byte per cycle. No bubbles inside a transaction.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE/RD/WR/DONE)
  - LEN_1B/LEN_2B/LEN_4B constants and a len-to-bytecount function
  - IO_BASE = 32'h30000
- Sub-module mem_arb_pick: combinational NUM_CH-wide fixed/round-robin picker. Inputs: req & ~abort and pointer. Outputs: one-hot grant and index.

Test Plan:
- 4B read, ch0 @0x100, RAM bytes 11,22,33,44: mem_a 0x100..0x103 in cycles 1-4, ch_done[0] in cycle 6, ch_rdata=0x44332211.
- 2B write, ch1 @0x2000, wdata=0xAABBCCDD: mem_wr=1 with (0x2000,DD),(0x2001,CC) in cycles 1-2, ch_done[1] in cycle 3, no other writes.
- Both channels requesting continuously, 1B reads: ARB_MODE=0 gives ch0 every grant; ARB_MODE=1 alternates grants 0,1,0,1.
- ch1 4B read @0x40, ch_abort[1] in cycle 2: no ch_done, mem_a stops after 0x41, IDLE next, a pending ch0 request is granted.
- rdy_in low for 3 cycles mid 4B write: mem_wr=0 and outputs held while low, the remaining bytes resume unchanged, done is delayed by exactly 3 cycles.
- 1B write to 0x30000 with 0x41 then rst pulse during a 4B read: a single IO write of 0x41, then all outputs 0 after reset and no ch_done.
